// File: rtl/background_scanner_pkg.sv
// rtl/background_scanner_pkg.sv - shared screen geometry, scan FSM states and pixel tag type
package background_scanner_pkg;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;
  localparam int COLOR_W  = 3;
  localparam int STATE_W  = 4;
  localparam int X_W      = 9;
  localparam int Y_W      = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DRAIN,
    S_DONE
  } scan_state_e;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
  } pixel_coord_t;

  localparam int COORD_W = $bits(pixel_coord_t);

endpackage

// File: rtl/pixel_delay_line.sv
// rtl/pixel_delay_line.sv - DEPTH-stage {valid, coord} shift line matching the background ROM latency
module pixel_delay_line #(
  parameter int DEPTH  = 1,
  parameter int DATA_W = 17
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_flush,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_empty,
  output logic              o_empty_next
);

  localparam logic [DEPTH-1:0] HEAD_MASK = DEPTH'(1) << (DEPTH - 1);

  logic [DEPTH-1:0]  r_valid;
  logic [DATA_W-1:0] r_data [DEPTH];

  // Stage 0 is the entry, stage DEPTH-1 is the head seen by the plot port.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_data[i] <= '0;
      end
    end else begin
      r_valid[0] <= i_valid & ~i_flush;
      r_data[0]  <= i_data;
      for (int i = 1; i < DEPTH; i++) begin
        r_valid[i] <= r_valid[i-1] & ~i_flush;
        r_data[i]  <= r_data[i-1];
      end
    end
  end

  assign o_valid      = r_valid[DEPTH-1];
  assign o_data       = r_data[DEPTH-1];
  assign o_empty      = ~|r_valid;
  // Empty after this edge when nothing is pushed: only the head may still hold a pixel.
  assign o_empty_next = ~|(r_valid & ~HEAD_MASK);

endmodule

// File: rtl/background_scanner.sv
// rtl/background_scanner.sv - raster-scan sequencer feeding getBackgroundPixel and the VGA write port
module background_scanner
  import background_scanner_pkg::*;
#(
  parameter int H_RES       = SCREEN_W,
  parameter int V_RES       = SCREEN_H,
  parameter int ROM_LATENCY = 1
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [STATE_W-1:0] game_state,
  input  logic               hold,
  output logic [STATE_W-1:0] bg_state,
  output logic [X_W-1:0]     bg_x,
  output logic [Y_W-1:0]     bg_y,
  input  logic [COLOR_W-1:0] bg_color,
  output logic [X_W-1:0]     vga_x,
  output logic [Y_W-1:0]     vga_y,
  output logic [COLOR_W-1:0] vga_colour,
  output logic               plot,
  output logic               busy,
  output logic               paused,
  output logic               done
);

  scan_state_e        r_state;
  scan_state_e        w_state_next;
  logic [STATE_W-1:0] r_bg_state;
  logic [X_W-1:0]     r_x;
  logic [Y_W-1:0]     r_y;

  logic               w_issue;
  logic               w_last_x;
  logic               w_last_y;
  logic               w_last_pixel;
  logic               w_busy;
  logic               w_done;
  pixel_coord_t       w_issue_coord;
  pixel_coord_t       w_head_coord;
  logic               w_head_valid;
  logic               w_pipe_empty;
  logic               w_pipe_empty_next;

  assign w_last_x     = (r_x == X_W'(H_RES - 1));
  assign w_last_y     = (r_y == Y_W'(V_RES - 1));
  assign w_last_pixel = w_last_x & w_last_y;
  // A start cycle never issues: the restart takes the coordinate reset instead.
  assign w_issue      = (r_state == S_SCAN) & ~hold & ~start;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_state_next = S_IDLE;
      end
      S_SCAN: begin
        w_busy = 1'b1;
        if (w_issue && w_last_pixel) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_busy = 1'b1;
        if (w_pipe_empty_next) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE: begin
        w_busy       = 1'b1;
        w_done       = ~start;
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
    if (start) begin
      w_state_next = S_SCAN;
    end
  end

  // Counters freeze on hold and stay on the last pixel once the frame is fully issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_bg_state <= '0;
      r_x        <= '0;
      r_y        <= '0;
    end else if (start) begin
      r_bg_state <= game_state;
      r_x        <= '0;
      r_y        <= '0;
    end else if (w_issue && !w_last_pixel) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= r_y + 1'b1;
      end else begin
        r_x <= r_x + 1'b1;
      end
    end
  end

  assign w_issue_coord.x = r_x;
  assign w_issue_coord.y = r_y;

  pixel_delay_line #(
    .DEPTH  (ROM_LATENCY),
    .DATA_W (COORD_W)
  ) u_delay (
    .clock        (clock),
    .reset        (reset),
    .i_flush      (start),
    .i_valid      (w_issue),
    .i_data       (w_issue_coord),
    .o_valid      (w_head_valid),
    .o_data       (w_head_coord),
    .o_empty      (w_pipe_empty),
    .o_empty_next (w_pipe_empty_next)
  );

  assign bg_state   = r_bg_state;
  assign bg_x       = r_x;
  assign bg_y       = r_y;
  assign plot       = w_head_valid;
  assign vga_x      = w_head_coord.x;
  assign vga_y      = w_head_coord.y;
  // ROM colour passes straight through, masked to zero when nothing is being plotted.
  assign vga_colour = w_head_valid ? bg_color : '0;
  assign busy       = w_busy;
  assign paused     = hold & w_pipe_empty;
  assign done       = w_done;

endmodule
